lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Upstream command feeder for the LCD image controller. Fetches 4-bit opcodes
//  from a command ROM and issues them one at a time on cmd/cmd_valid under the
//  controller's busy/done handshake. Stops on an END opcode, after a write
//  completes, or when the ROM is exhausted. A watchdog flags a controller stall.
// PARAMETERS
//  ADDR_W     4     command ROM address width; depth = 2**ADDR_W
//  END_CODE   4'hF  opcode that terminates the script; it is never issued
//  WDOG_MAX   255   max cycles busy_in/done_in may be awaited before err
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high
//  start      in   1       1-cycle pulse; begins script at address 0 when idle
//  CMD_Q      in   4       command ROM data, valid 1 cycle after CMD_A/CMD_rd
//  CMD_rd     out  1       command ROM read enable
//  CMD_A      out  ADDR_W  command ROM address
//  busy       in   1       controller busy (registered in controller)
//  done       in   1       controller image-write-complete flag
//  cmd        out  4       opcode to controller
//  cmd_valid  out  1       1-cycle strobe qualifying cmd
//  seq_busy   out  1       high from start accepted until END/ERR
//  seq_done   out  1       high when script finished cleanly; held until start
//  err        out  1       watchdog expired; held until reset or start
// BEHAVIOUR
//  Reset: CMD_rd=0, CMD_A=0, cmd=0, cmd_valid=0, seq_busy=0, seq_done=0,
//   err=0, wdog=0, state=IDLE. All outputs are registered.
//  FSM (registered):
//   IDLE : start=1 -> CMD_A<=0, CMD_rd<=1, seq_busy<=1, seq_done<=0, err<=0,
//          -> FETCH. start ignored in every other state.
//   FETCH: ROM access cycle; CMD_rd<=0 -> DECODE.
//   DECODE: CMD_Q==END_CODE -> END. Else latch cmd<=CMD_Q, -> WAIT_RDY.
//   WAIT_RDY: busy==0 -> cmd_valid<=1 -> ISSUE. Else wdog++.
//   ISSUE: cmd_valid<=0 (strobe exactly 1 cycle). cmd==0 (write) -> WAIT_DONE;
//          else -> GAP.
//   GAP  : mandatory idle cycle (controller sees cmd_valid=0). If
//          CMD_A==2**ADDR_W-1 -> END; else CMD_A<=CMD_A+1, CMD_rd<=1 -> FETCH.
//   WAIT_DONE: done==1 -> END (write is terminal for the controller).
//          Else wdog++.
//   END  : seq_busy<=0, seq_done<=1 -> IDLE.
//   ERR  : seq_busy<=0, err<=1, cmd_valid<=0 -> IDLE.
//  Issue rate: one opcode per 4 cycles minimum (FETCH,DECODE,WAIT_RDY,ISSUE)
//   plus GAP; cmd_valid is never high on two consecutive cycles.
//  cmd holds its value from DECODE until the next DECODE.
//  Watchdog: 8-bit counter cleared on every state change; while in WAIT_RDY or
//   WAIT_DONE, reaching WDOG_MAX -> ERR. cmd_valid never asserted after ERR.
//  Opcodes 12..14 are forwarded unchanged (controller treats them as no-op).
//  Boundaries: END_CODE at addr 0 -> seq_done after 3 cycles, no cmd_valid.
//   Last ROM address without END_CODE -> END after its GAP (no wrap).
//   busy high at start (controller still loading) -> held in WAIT_RDY.
//   Reset mid-script -> immediate return to reset values; no partial strobe.
// TESTING
//  1 ROM={1,4,7,F}, busy=0 -> cmd_valid pulses for 1,4,7 each 1 cycle, >=5
//    cycles apart; seq_done=1, err=0, CMD_A stops at 3.
//  2 ROM={F,...} -> seq_done 3 cycles after start, cmd_valid never high.
//  3 busy=1 for 64 cycles after start, ROM={3,F} -> cmd=3 strobed on cycle
//    busy first samples 0 (+1), err=0.
//  4 ROM={5,0,2}, done after 70 cycles -> cmds 5,0 issued, 2 never issued,
//    seq_done rises 1 cycle after done.
//  5 busy stuck 1, WDOG_MAX=255 -> err=1 after 255 WAIT_RDY cycles,
//    seq_busy=0, no cmd_valid; new start clears err.
//  6 ROM all 16 entries =1 (no END) -> 16 strobes, END after addr 15,
//    CMD_A==15; reset pulse mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// Command-ROM sequencer for the LCD image controller: fetches opcodes, issues
// them under the busy/done handshake and guards each wait with a watchdog.
module lcd_cmd_sequencer #(
  parameter int         ADDR_W   = 4,
  parameter logic [3:0] END_CODE = 4'hF,
  parameter int         WDOG_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        CMD_Q,
  output logic              CMD_rd,
  output logic [ADDR_W-1:0] CMD_A,
  input  logic              busy,
  input  logic              done,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              err
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_WAIT_RDY  = 4'd3,
    ST_ISSUE     = 4'd4,
    ST_GAP       = 4'd5,
    ST_WAIT_DONE = 4'd6,
    ST_END       = 4'd7,
    ST_ERR       = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        WDOG_LAST = 8'(WDOG_MAX - 32'sd1);

  state_t            state_r, state_s;
  logic              cmd_rd_r, cmd_rd_s;
  logic [ADDR_W-1:0] cmd_a_r, cmd_a_s;
  logic [3:0]        cmd_r, cmd_s;
  logic              cmd_valid_r, cmd_valid_s;
  logic              seq_busy_r, seq_busy_s;
  logic              seq_done_r, seq_done_s;
  logic              err_r, err_s;
  logic [7:0]        wdog_r, wdog_s;

  // Next-state and next-output logic; cmd_valid defaults low so every strobe lasts one cycle.
  always_comb begin
    state_s     = state_r;
    cmd_rd_s    = cmd_rd_r;
    cmd_a_s     = cmd_a_r;
    cmd_s       = cmd_r;
    cmd_valid_s = 1'b0;
    seq_busy_s  = seq_busy_r;
    seq_done_s  = seq_done_r;
    err_s       = err_r;
    wdog_s      = wdog_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cmd_a_s    = {ADDR_W{1'b0}};
          cmd_rd_s   = 1'b1;
          seq_busy_s = 1'b1;
          seq_done_s = 1'b0;
          err_s      = 1'b0;
          state_s    = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        cmd_rd_s = 1'b0;
        state_s  = ST_DECODE;
      end
      ST_DECODE: begin
        if (CMD_Q == END_CODE) begin
          state_s = ST_END;
        end else begin
          cmd_s   = CMD_Q;
          state_s = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (!busy) begin
          cmd_valid_s = 1'b1;
          state_s     = ST_ISSUE;
        end else if (wdog_r == WDOG_LAST) begin
          state_s = ST_ERR;
        end else begin
          wdog_s = wdog_r + 8'd1;
        end
      end
      ST_ISSUE: begin
        // opcode 0 is an image write, which ends the script once done arrives
        if (cmd_r == 4'd0) begin
          state_s = ST_WAIT_DONE;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cmd_a_r == ADDR_LAST) begin
          state_s = ST_END;
        end else begin
          cmd_a_s  = cmd_a_r + ADDR_ONE;
          cmd_rd_s = 1'b1;
          state_s  = ST_FETCH;
        end
      end
      ST_WAIT_DONE: begin
        if (done) begin
          state_s = ST_END;
        end else if (wdog_r == WDOG_LAST) begin
          state_s = ST_ERR;
        end else begin
          wdog_s = wdog_r + 8'd1;
        end
      end
      ST_END: begin
        seq_busy_s = 1'b0;
        seq_done_s = 1'b1;
        state_s    = ST_IDLE;
      end
      ST_ERR: begin
        seq_busy_s = 1'b0;
        err_s      = 1'b1;
        state_s    = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (state_s != state_r) begin
      wdog_s = 8'd0;
    end else begin
      wdog_s = wdog_s;
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_rd_r    <= 1'b0;
      cmd_a_r     <= {ADDR_W{1'b0}};
      cmd_r       <= 4'd0;
      cmd_valid_r <= 1'b0;
      seq_busy_r  <= 1'b0;
      seq_done_r  <= 1'b0;
      err_r       <= 1'b0;
      wdog_r      <= 8'd0;
    end else begin
      state_r     <= state_s;
      cmd_rd_r    <= cmd_rd_s;
      cmd_a_r     <= cmd_a_s;
      cmd_r       <= cmd_s;
      cmd_valid_r <= cmd_valid_s;
      seq_busy_r  <= seq_busy_s;
      seq_done_r  <= seq_done_s;
      err_r       <= err_s;
      wdog_r      <= wdog_s;
    end
  end

  assign CMD_rd    = cmd_rd_r;
  assign CMD_A     = cmd_a_r;
  assign cmd       = cmd_r;
  assign cmd_valid = cmd_valid_r;
  assign seq_busy  = seq_busy_r;
  assign seq_done  = seq_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: stimulus queues expected strobes,
// completions and errors with their cycle; a negedge monitor pops and compares.
module tb_lcd_cmd_sequencer;

  localparam int K_CMD  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] CMD_Q = 4'd0;
  logic       CMD_rd;
  logic [3:0] CMD_A;
  logic       busy;
  logic       done;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       seq_busy;
  logic       seq_done;
  logic       err;

  logic [3:0] rom [16];
  exp_t       exp_q [$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       prev_valid = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;

  lcd_cmd_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .CMD_Q(CMD_Q), .CMD_rd(CMD_rd),
    .CMD_A(CMD_A), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
    .seq_busy(seq_busy), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (CMD_rd) CMD_Q <= rom[CMD_A];
  end

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] data, input int c);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [3:0] data);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind %0d data %0d at cycle %0d, nothing expected", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d data %0d cycle %0d expected kind %0d data %0d cycle %0d",
                 kind, data, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe, seq_done rise and err rise is matched against the queue.
  always @(negedge clk) begin
    if (cmd_valid) begin
      chk("strobe_not_back_to_back", int'(prev_valid), 0);
      pop_cmp(K_CMD, cmd);
    end
    if (seq_done && !prev_done) pop_cmp(K_DONE, {3'd0, err});
    if (err && !prev_err) pop_cmp(K_ERR, {3'd0, seq_busy});
    prev_valid = cmd_valid;
    prev_done  = seq_done;
    prev_err   = err;
  end

  task automatic do_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_rom(input logic [3:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_CMD_rd"}, int'(CMD_rd), 0);
    chk({tag, "_CMD_A"}, int'(CMD_A), 0);
    chk({tag, "_cmd"}, int'(cmd), 0);
    chk({tag, "_cmd_valid"}, int'(cmd_valid), 0);
    chk({tag, "_seq_busy"}, int'(seq_busy), 0);
    chk({tag, "_seq_done"}, int'(seq_done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int s;
    reset = 1'b1;
    start = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    fill_rom(4'hF);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // 1: three opcodes then END
    fill_rom(4'hF);
    rom[0] = 4'd1; rom[1] = 4'd4; rom[2] = 4'd7;
    do_start(s);
    push(K_CMD, 4'd1, s + 3);
    push(K_CMD, 4'd4, s + 8);
    push(K_CMD, 4'd7, s + 13);
    push(K_DONE, 4'd0, s + 18);
    wait_drain(60);
    chk("t1_CMD_A", int'(CMD_A), 3);
    chk("t1_seq_busy", int'(seq_busy), 0);
    chk("t1_seq_done_held", int'(seq_done), 1);

    // 2: END at address 0
    fill_rom(4'hF);
    do_start(s);
    chk("t2_seq_done_cleared", int'(seq_done), 0);
    push(K_DONE, 4'd0, s + 3);
    wait_drain(20);

    // 3: controller busy for 64 cycles after start
    fill_rom(4'hF);
    rom[0] = 4'd3;
    busy = 1'b1;
    do_start(s);
    push(K_CMD, 4'd3, s + 64);
    push(K_DONE, 4'd0, s + 69);
    repeat (63) @(negedge clk);
    busy = 1'b0;
    wait_drain(40);
    chk("t3_err", int'(err), 0);

    // 4: write opcode is terminal; opcode 2 must never be issued
    fill_rom(4'hF);
    rom[0] = 4'd5; rom[1] = 4'd0; rom[2] = 4'd2;
    do_start(s);
    push(K_CMD, 4'd5, s + 3);
    push(K_CMD, 4'd0, s + 8);
    push(K_DONE, 4'd0, s + 72);
    repeat (70) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_drain(20);
    chk("t4_CMD_A", int'(CMD_A), 1);

    // 5: busy stuck -> watchdog error, then a new start clears it
    fill_rom(4'hF);
    rom[0] = 4'd3;
    busy = 1'b1;
    do_start(s);
    push(K_ERR, 4'd0, s + 258);
    wait_drain(300);
    chk("t5_err_held", int'(err), 1);
    chk("t5_seq_done", int'(seq_done), 0);
    busy = 1'b0;
    do_start(s);
    chk("t5_err_cleared", int'(err), 0);
    chk("t5_seq_busy", int'(seq_busy), 1);
    push(K_CMD, 4'd3, s + 3);
    push(K_DONE, 4'd0, s + 8);
    wait_drain(30);

    // 6: no END in ROM -> 16 strobes, stops at the last address
    fill_rom(4'd1);
    do_start(s);
    for (int i = 0; i < 16; i++) push(K_CMD, 4'd1, s + 3 + 5 * i);
    push(K_DONE, 4'd0, s + 81);
    wait_drain(120);
    chk("t6_CMD_A", int'(CMD_A), 15);

    // 6b: reset in the middle of a script
    do_start(s);
    push(K_CMD, 4'd1, s + 3);
    repeat (5) @(negedge clk);
    chk("t6b_CMD_rd_before", int'(CMD_rd), 1);
    chk("t6b_CMD_A_before", int'(CMD_A), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6b_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
